// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder.
//   XLEN       : machine word width
//   NOP        : RV32I canonical NOP (addi x0, x0, 0)
//   state_t    : responder FSM states
//   addr_fault : true when a byte address is misaligned or beyond the store
package core_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word address must be 4-byte aligned and inside depth*4 bytes.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] w_limit;
        w_limit = 34'(depth) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= w_limit);
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Instruction-fetch and program-load bus between IF (master) and the
// instruction memory responder (slave).
//   Request side : inst_mem_read_enable, inst_mem_read_addr, IF_kick_up
//   Load side    : load_enable, load_addr, load_data
//   Response side: inst_mem_read_data, inst_mem_kick_up, inst_mem_busy,
//                  inst_mem_fault, req_overrun, dbg_state
//
// Handshake: a request is presented in any cycle where IF_kick_up and
// inst_mem_read_enable are both high; it is accepted on that clock edge only
// if the responder is idle (inst_mem_busy low), otherwise it is dropped and
// req_overrun latches high. There is no ready/backpressure; the master must
// space requests at least LATENCY+1 cycles apart. inst_mem_kick_up is a
// one-cycle valid pulse for inst_mem_read_data/inst_mem_fault, which then
// hold until the next pulse. load_enable writes every cycle it is high.
interface inst_mem_responder_if;
    import core_pkg::*;

    logic            inst_mem_read_enable;
    logic [XLEN-1:0] inst_mem_read_addr;
    logic            IF_kick_up;
    logic            load_enable;
    logic [XLEN-1:0] load_addr;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] inst_mem_read_data;
    logic            inst_mem_kick_up;
    logic            inst_mem_busy;
    logic            inst_mem_fault;
    logic            req_overrun;
    state_t          dbg_state;

    modport master (
        output inst_mem_read_enable, inst_mem_read_addr, IF_kick_up,
               load_enable, load_addr, load_data,
        input  inst_mem_read_data, inst_mem_kick_up, inst_mem_busy,
               inst_mem_fault, req_overrun, dbg_state
    );

    modport slave (
        input  inst_mem_read_enable, inst_mem_read_addr, IF_kick_up,
               load_enable, load_addr, load_data,
        output inst_mem_read_data, inst_mem_kick_up, inst_mem_busy,
               inst_mem_fault, req_overrun, dbg_state
    );

endinterface

// File: rtl/inst_mem_responder_array.sv
// Word-addressed instruction store: one synchronous write port, one
// combinational read port, no reset on contents.
//   i_clk   : clock
//   i_we    : write strobe
//   i_waddr : write word index
//   i_wdata : write word
//   i_raddr : read word index
//   o_rdata : read word (old contents when written in the same cycle)
module inst_mem_array
    import core_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: accepts a fetch while idle, captures the
// addressed word (or RESET_DATA on a fault) at acceptance, and returns it with
// a one-cycle inst_mem_kick_up pulse LATENCY cycles later.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fetch/load/response bus (slave side); see inst_mem_responder_if
// LATENCY must lie in 1..15 (4-bit counter).
module inst_mem_responder
    import core_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] RESET_DATA = NOP
) (
    input  logic               clk,
    input  logic               reset,
    inst_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t          r_state;
    state_t          w_next_state;
    logic [3:0]      r_counter;
    logic [XLEN-1:0] r_hold;
    logic            r_hold_fault;
    logic [XLEN-1:0] r_read_data;
    logic            r_fault;
    logic            r_overrun;

    logic            w_req;
    logic            w_accept;
    logic            w_rd_fault;
    logic            w_ld_fault;
    logic            w_we;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_fetch;

    assign w_req      = bus.IF_kick_up && bus.inst_mem_read_enable;
    assign w_rd_fault = addr_fault(bus.inst_mem_read_addr, DEPTH);
    assign w_ld_fault = addr_fault(bus.load_addr, DEPTH);
    assign w_we       = bus.load_enable && !w_ld_fault;
    assign w_fetch    = w_rd_fault ? RESET_DATA : w_rdata;

    inst_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (bus.load_addr[AW+1:2]),
        .i_wdata (bus.load_data),
        .i_raddr (bus.inst_mem_read_addr[AW+1:2]),
        .o_rdata (w_rdata)
    );

    // The counter is loaded with LATENCY-1 and WAIT is left on the edge where
    // it reaches zero, so WAIT lasts LATENCY-1 cycles and RESP falls exactly
    // LATENCY cycles after acceptance.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_counter == 4'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_counter    <= 4'd0;
            r_hold       <= RESET_DATA;
            r_hold_fault <= 1'b0;
            r_read_data  <= RESET_DATA;
            r_fault      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_counter    <= 4'(LATENCY - 1);
                r_hold       <= w_fetch;
                r_hold_fault <= w_rd_fault;
            end else if (r_state == WAIT) begin
                r_counter <= r_counter - 4'd1;
            end

            // Publish on entry to RESP; with LATENCY=1 the entry edge is the
            // acceptance edge itself, so bypass the holding register.
            if (w_next_state == RESP && r_state != RESP) begin
                r_read_data <= w_accept ? w_fetch    : r_hold;
                r_fault     <= w_accept ? w_rd_fault : r_hold_fault;
            end

            if (w_req && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.inst_mem_read_data = r_read_data;
    assign bus.inst_mem_kick_up   = (r_state == RESP);
    assign bus.inst_mem_busy      = (r_state != IDLE);
    assign bus.inst_mem_fault     = r_fault;
    assign bus.req_overrun        = r_overrun;
    assign bus.dbg_state          = r_state;

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;
  import core_pkg::*;

  localparam int TB_DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_mem_responder_if bus2();
  inst_mem_responder_if bus1();

  inst_mem_responder #(.DEPTH(TB_DEPTH), .LATENCY(2), .RESET_DATA(32'h00000013)) u_dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2)
  );

  inst_mem_responder #(.DEPTH(TB_DEPTH), .LATENCY(1), .RESET_DATA(32'h00000013)) u_dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [31:0] model_mem [int];

  function automatic logic exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= TB_DEPTH * 4);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (exp_fault(a)) return 32'h00000013;
    if (model_mem.exists(int'(a / 4))) return model_mem[int'(a / 4)];
    return 32'hxxxxxxxx;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_data(input int sel);
    return (sel == 1) ? bus1.inst_mem_read_data : bus2.inst_mem_read_data;
  endfunction
  function automatic logic get_kick(input int sel);
    return (sel == 1) ? bus1.inst_mem_kick_up : bus2.inst_mem_kick_up;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus1.inst_mem_busy : bus2.inst_mem_busy;
  endfunction
  function automatic logic get_fault(input int sel);
    return (sel == 1) ? bus1.inst_mem_fault : bus2.inst_mem_fault;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_req(input int sel, input logic v, input logic [31:0] a);
    if (sel == 1) begin
      bus1.IF_kick_up = v;
      bus1.inst_mem_read_enable = v;
      bus1.inst_mem_read_addr = a;
    end else begin
      bus2.IF_kick_up = v;
      bus2.inst_mem_read_enable = v;
      bus2.inst_mem_read_addr = a;
    end
  endtask

  // Loads go to both stores so they hold identical programs.
  task automatic set_load(input logic v, input logic [31:0] a, input logic [31:0] d);
    bus1.load_enable = v;
    bus1.load_addr = a;
    bus1.load_data = d;
    bus2.load_enable = v;
    bus2.load_addr = a;
    bus2.load_data = d;
  endtask

  // All drivers start and end at posedge+1.
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    set_load(1'b1, a, d);
    @(posedge clk); #1;
    set_load(1'b0, 32'h0, 32'h0);
    if (!exp_fault(a)) model_mem[int'(a / 4)] = d;
  endtask

  task automatic fetch(input int sel, input logic [31:0] addr, input int lat, input string tag,
                       input logic ld, input logic [31:0] ld_addr, input logic [31:0] ld_data);
    logic [31:0] e_data;
    logic e_fault;
    int off;
    logic found;
    e_fault = exp_fault(addr);
    e_data = exp_word(addr);
    set_req(sel, 1'b1, addr);
    if (ld) set_load(1'b1, ld_addr, ld_data);
    @(posedge clk); #1;
    set_req(sel, 1'b0, 32'h0);
    set_load(1'b0, 32'h0, 32'h0);
    if (ld && !exp_fault(ld_addr)) model_mem[int'(ld_addr / 4)] = ld_data;
    off = 1;
    found = 1'b0;
    while (!found && off <= 20) begin
      if (get_kick(sel)) found = 1'b1;
      else begin
        chk({tag, "_busy_wait"}, 32'(get_busy(sel)), 32'd1);
        @(posedge clk); #1;
        off++;
      end
    end
    chk({tag, "_pulse_seen"}, 32'(found), 32'd1);
    chk({tag, "_latency"}, off, lat);
    chk({tag, "_data"}, get_data(sel), e_data);
    chk({tag, "_fault"}, 32'(get_fault(sel)), 32'(e_fault));
    chk({tag, "_busy_resp"}, 32'(get_busy(sel)), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_kick_one_cycle"}, 32'(get_kick(sel)), 32'd0);
    chk({tag, "_busy_after"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, "_data_hold"}, get_data(sel), e_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] addrs [3];
    int r;

    set_req(1, 1'b0, 32'h0);
    set_req(2, 1'b0, 32'h0);
    set_load(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values
    chk("rst_data", bus2.inst_mem_read_data, 32'h00000013);
    chk("rst_kick", 32'(bus2.inst_mem_kick_up), 32'd0);
    chk("rst_busy", 32'(bus2.inst_mem_busy), 32'd0);
    chk("rst_fault", 32'(bus2.inst_mem_fault), 32'd0);
    chk("rst_overrun", 32'(bus2.req_overrun), 32'd0);
    chk("rst_data_l1", bus1.inst_mem_read_data, 32'h00000013);

    // basic read
    load(32'h0, 32'h00500093);
    fetch(2, 32'h0, 2, "t1_read0", 1'b0, 32'h0, 32'h0);

    // faults and range edges
    fetch(2, 32'h2, 2, "t2_misaligned", 1'b0, 32'h0, 32'h0);
    load(32'hFFC, 32'hDEADBEEF);
    fetch(2, 32'hFFC, 2, "t2_last_word", 1'b0, 32'h0, 32'h0);
    fetch(2, 32'h1000, 2, "t2_out_of_range", 1'b0, 32'h0, 32'h0);

    // enable low with strobe high: neither request nor overrun
    bus2.IF_kick_up = 1'b1;
    bus2.inst_mem_read_addr = 32'h0;
    @(posedge clk); #1;
    bus2.IF_kick_up = 1'b0;
    chk("noen_busy", 32'(bus2.inst_mem_busy), 32'd0);
    chk("noen_overrun", 32'(bus2.req_overrun), 32'd0);

    // overrun: second request one cycle after acceptance
    set_req(2, 1'b1, 32'h0);
    @(posedge clk); #1;
    chk("t3_busy_k1", 32'(bus2.inst_mem_busy), 32'd1);
    set_req(2, 1'b1, 32'h4);
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0);
    chk("t3_kick_k2", 32'(bus2.inst_mem_kick_up), 32'd1);
    chk("t3_data_k2", bus2.inst_mem_read_data, exp_word(32'h0));
    chk("t3_overrun_set", 32'(bus2.req_overrun), 32'd1);
    @(posedge clk); #1;
    chk("t3_kick_k3", 32'(bus2.inst_mem_kick_up), 32'd0);
    chk("t3_busy_k3", 32'(bus2.inst_mem_busy), 32'd0);
    set_req(2, 1'b1, 32'hFFC);
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0);
    chk("t3_accept_k4", 32'(bus2.inst_mem_busy), 32'd1);
    chk("t3_kick_k4", 32'(bus2.inst_mem_kick_up), 32'd0);
    @(posedge clk); #1;
    chk("t3_kick_k5", 32'(bus2.inst_mem_kick_up), 32'd1);
    chk("t3_data_k5", bus2.inst_mem_read_data, exp_word(32'hFFC));
    @(posedge clk); #1;
    chk("t3_overrun_sticky", 32'(bus2.req_overrun), 32'd1);

    // same-cycle load and read to one word returns the old word
    load(32'h10, 32'h11111111);
    fetch(2, 32'h10, 2, "t4_old_word", 1'b1, 32'h10, 32'h22222222);
    fetch(2, 32'h10, 2, "t4_new_word", 1'b0, 32'h0, 32'h0);

    // randomized program and fetches
    for (int i = 0; i < 32; i++) load(32'(i * 4), $urandom);
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        load(32'($urandom_range(0, 31) * 4), $urandom);
      end else if (r == 3) begin
        // dropped loads: would alias a live word if range/alignment were ignored
        if ($urandom_range(0, 1) == 1) a = 32'h1000 + 32'($urandom_range(0, 31) * 4);
        else a = 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(1, 3));
        load(a, $urandom);
      end
      r = $urandom_range(0, 5);
      if (r < 3) a = 32'($urandom_range(0, 31) * 4);
      else if (r == 3) a = 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(1, 3));
      else if (r == 4) a = 32'h1000 + 32'($urandom_range(0, 1023) * 4);
      else a = $urandom | 32'h8000_0000;
      fetch(2, a, 2, "rnd", 1'b0, 32'h0, 32'h0);
    end
    chk("overrun_still_set", 32'(bus2.req_overrun), 32'd1);

    // reset during WAIT
    fetch(2, 32'h1000, 2, "t5_pre_fault", 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b1, 32'h0);
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0);
    chk("t5_in_wait", 32'(bus2.inst_mem_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_data", bus2.inst_mem_read_data, 32'h00000013);
    chk("t5_rst_busy", 32'(bus2.inst_mem_busy), 32'd0);
    chk("t5_rst_kick", 32'(bus2.inst_mem_kick_up), 32'd0);
    chk("t5_rst_fault", 32'(bus2.inst_mem_fault), 32'd0);
    chk("t5_rst_overrun", 32'(bus2.req_overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_pulse", 32'(bus2.inst_mem_kick_up), 32'd0);
      @(posedge clk); #1;
    end
    fetch(2, 32'h0, 2, "t5_store_kept", 1'b0, 32'h0, 32'h0);

    // LATENCY=1 back-to-back every 2 cycles
    load(32'h0, 32'hA0A0A0A0);
    load(32'h4, 32'hB1B1B1B1);
    load(32'h8, 32'hC2C2C2C2);
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h8;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1 && k <= 5) begin
        chk("t6_kick", 32'(bus1.inst_mem_kick_up), 32'd1);
        chk("t6_data", bus1.inst_mem_read_data, exp_word(addrs[(k - 1) / 2]));
        chk("t6_fault", 32'(bus1.inst_mem_fault), 32'd0);
      end else begin
        chk("t6_no_kick", 32'(bus1.inst_mem_kick_up), 32'd0);
      end
      if (k % 2 == 0 && k <= 4) set_req(1, 1'b1, addrs[k / 2]);
      else set_req(1, 1'b0, 32'h0);
      @(posedge clk); #1;
    end
    chk("t6_overrun", 32'(bus1.req_overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
